// File: rtl/dmem_srqtype_regout_pkg.sv
// Shared decoder parameters for the message memory: geometry of one stored word
// and of the layer/address space.
package dmem_srqtype_regout_pkg;

  localparam int unsigned DMEM_W            = 6;
  localparam int unsigned DMEM_P            = 26;
  localparam int unsigned DMEM_NB           = 16;
  localparam int unsigned DMEM_WT           = 2;
  localparam int unsigned DMEM_ADDRESSWIDTH = 5;
  localparam int unsigned DMEM_ADDRDEPTH    = 20;
  localparam int unsigned DMEM_LAYERS       = 2;
  localparam int unsigned DMEM_DW           = DMEM_P * DMEM_NB * DMEM_WT * DMEM_W;
  localparam int unsigned DMEM_DEPTH        = DMEM_ADDRDEPTH * DMEM_LAYERS;

endpackage

// File: rtl/dmem_srqtype_regout_wr_ptr.sv
// Auto-incrementing write pointer: walks address 0..ADDRDEPTH-1 within a layer,
// then moves to the other layer.
module dmem_wr_ptr #(
  parameter int unsigned ADDRESSWIDTH = 5,
  parameter int unsigned ADDRDEPTH    = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  output logic [ADDRESSWIDTH-1:0] wr_addr,
  output logic                    wr_layer
);

  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(ADDRDEPTH - 1);

  logic [ADDRESSWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                    wr_layer_q, wr_layer_d;

  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_layer_d = wr_layer_q;
    if (adv) begin
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d  = '0;
        wr_layer_d = ~wr_layer_q;
      end else begin
        wr_addr_d  = wr_addr_q + ADDRESSWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      wr_layer_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      wr_layer_q <= wr_layer_d;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_layer = wr_layer_q;

endmodule

// File: rtl/dmem_srqtype_regout.sv
// Two-layer message memory with an internal write pointer and a registered,
// enable-held read port. Array contents survive reset.
module dmem_srqtype_regout
  import dmem_srqtype_regout_pkg::*;
#(
  parameter  int unsigned W            = DMEM_W,
  parameter  int unsigned P            = DMEM_P,
  parameter  int unsigned NB           = DMEM_NB,
  parameter  int unsigned WT           = DMEM_WT,
  parameter  int unsigned ADDRESSWIDTH = DMEM_ADDRESSWIDTH,
  parameter  int unsigned ADDRDEPTH    = DMEM_ADDRDEPTH,
  parameter  int unsigned LAYERS       = DMEM_LAYERS,
  localparam int unsigned DW           = P * NB * WT * W,
  localparam int unsigned DEPTH        = ADDRDEPTH * LAYERS
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [DW-1:0]           rd_data_regout,
  input  logic                    rd_en,
  input  logic [ADDRESSWIDTH-1:0] rd_address,
  input  logic                    rd_layer,
  input  logic [DW-1:0]           wr_data,
  input  logic                    wr_en
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam logic [ADDRESSWIDTH:0] ADDR_LIM = (ADDRESSWIDTH + 1)'(ADDRDEPTH);

  logic [DW-1:0]           mem [DEPTH];
  logic [ADDRESSWIDTH-1:0] wr_addr;
  logic                    wr_layer;
  logic [IDXW-1:0]         wr_idx, rd_idx;
  logic                    rd_in_range;
  logic [DW-1:0]           rd_data_q, rd_data_d;

  dmem_wr_ptr #(
    .ADDRESSWIDTH (ADDRESSWIDTH),
    .ADDRDEPTH    (ADDRDEPTH)
  ) u_wr_ptr (
    .clk      (clk),
    .rst_n    (rst),
    .adv      (wr_en),
    .wr_addr  (wr_addr),
    .wr_layer (wr_layer)
  );

  always_comb begin
    wr_idx      = IDXW'(wr_layer) * IDXW'(ADDRDEPTH) + IDXW'(wr_addr);
    rd_idx      = IDXW'(rd_layer) * IDXW'(ADDRDEPTH) + IDXW'(rd_address);
    rd_in_range = {1'b0, rd_address} < ADDR_LIM;
  end

  // No reset on the array; a write coinciding with reset low is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_in_range ? mem[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_regout = rd_data_q;

endmodule

// File: tb/tb_dmem_srqtype_regout.sv
// Directed bench for dmem_srqtype_regout: reset, fill, layer wrap,
// read-during-write, output hold, out-of-range reads, persistence across reset.
module tb_dmem_srqtype_regout;
  import dmem_srqtype_regout_pkg::*;

  localparam int unsigned DW = DMEM_DW;
  localparam int unsigned AW = DMEM_ADDRESSWIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rd_data_regout;
  logic          rd_en;
  logic [AW-1:0] rd_address;
  logic          rd_layer;
  logic [DW-1:0] wr_data;
  logic          wr_en;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  dmem_srqtype_regout dut (
    .clk            (clk),
    .rst            (rst),
    .rd_data_regout (rd_data_regout),
    .rd_en          (rd_en),
    .rd_address     (rd_address),
    .rd_layer       (rd_layer),
    .wr_data        (wr_data),
    .wr_en          (wr_en)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    int first_bad;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      first_bad = -1;
      for (int i = 0; i < int'(DW); i++) begin
        if (first_bad < 0 && got[i] !== exp[i]) first_bad = i;
      end
      $display("FAIL %s: got[63:0]=%h required[63:0]=%h (first differing bit %0d)",
               tag, got[63:0], exp[63:0], first_bad);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                      input logic lay, input logic [AW-1:0] addr);
    @(negedge clk);
    wr_en      = we;
    wr_data    = wd;
    rd_en      = re;
    rd_layer   = lay;
    rd_address = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    rd_en      = 1'b0;
    rd_address = '0;
    rd_layer   = 1'b0;
    wr_data    = '0;
    wr_en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", rd_data_regout, '0);

    // A few writes and a read, then reset asserted mid-stream with wr_en high.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, pat(8'h55), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, AW'(0));
    check("pre_read", rd_data_regout, pat(8'h55));
    @(negedge clk);
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_data = pat(8'h33);
    #1;
    check("async_clear", rd_data_regout, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;

    // Fill layer 0 starting at address 0.
    for (int k = 0; k < 20; k++) step(1'b1, pat(8'(k)), 1'b0, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, '0, 1'b1, 1'b0, AW'(k));
      check($sformatf("fill_l0_a%0d", k), rd_data_regout, pat(8'(k)));
    end

    // 21st write crosses into layer 1.
    step(1'b1, pat(8'hAA), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, AW'(0));
    check("wrap_l1_a0", rd_data_regout, pat(8'hAA));
    step(1'b0, '0, 1'b1, 1'b0, AW'(0));
    check("wrap_l0_a0_kept", rd_data_regout, pat(8'h00));

    // Memory persists across reset.
    reset_pulse();
    step(1'b0, '0, 1'b1, 1'b0, AW'(19));
    check("persist_l0_a19", rd_data_regout, pat(8'd19));

    // Read-during-write: A at L0A0, reset pointer, write B there while reading.
    reset_pulse();
    step(1'b1, pat(8'hA1), 1'b0, 1'b0, '0);
    reset_pulse();
    step(1'b1, pat(8'hB2), 1'b1, 1'b0, AW'(0));
    check("rdw_old", rd_data_regout, pat(8'hA1));
    step(1'b0, '0, 1'b1, 1'b0, AW'(0));
    check("rdw_new", rd_data_regout, pat(8'hB2));

    // Hold while rd_en low.
    step(1'b0, '0, 1'b0, 1'b0, AW'(1));
    check("hold_a1", rd_data_regout, pat(8'hB2));
    step(1'b0, '0, 1'b0, 1'b1, AW'(5));
    check("hold_a5", rd_data_regout, pat(8'hB2));
    step(1'b0, '0, 1'b0, 1'b0, AW'(25));
    check("hold_a25", rd_data_regout, pat(8'hB2));

    // Out-of-range addresses read as zero.
    step(1'b0, '0, 1'b1, 1'b0, AW'(25));
    check("oor_a25", rd_data_regout, '0);
    step(1'b0, '0, 1'b1, 1'b1, AW'(20));
    check("oor_l1_a20", rd_data_regout, '0);

    // 41 writes from reset: layer 1 wraps back to layer 0 address 0.
    reset_pulse();
    for (int i = 0; i < 41; i++) step(1'b1, pat(8'(i + 100)), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b1, AW'(19));
    check("full_l1_a19", rd_data_regout, pat(8'd139));
    step(1'b0, '0, 1'b1, 1'b0, AW'(0));
    check("full_wrap_l0_a0", rd_data_regout, pat(8'd140));
    step(1'b0, '0, 1'b1, 1'b0, AW'(1));
    check("full_l0_a1", rd_data_regout, pat(8'd101));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_srqtype_regout.md
DMEM_SRQTYPE_REGOUT -- requirements
Module: dmem_srqtype_regout

Interface
REQ-001 SHALL have parameter W, default 6: message word width in bits.
REQ-002 SHALL have parameter P, default 26: parallel rows per address.
REQ-003 SHALL have parameter NB, default 16: circulant block columns.
REQ-004 SHALL have parameter WT, default 2: circulant weight.
REQ-005 SHALL have parameter ADDRESSWIDTH, default 5: read address width.
REQ-006 SHALL have parameter ADDRDEPTH, default 20: valid addresses per layer (0..19).
REQ-007 SHALL have parameter LAYERS, default 2: number of layers.
REQ-008 SHALL derive DW = P*NB*WT*W (4992 at defaults) and DEPTH = ADDRDEPTH*LAYERS (40 at defaults).
REQ-009 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have port rd_data_regout, output, DW bits: registered read data.
REQ-012 SHALL have port rd_en, input, 1 bit: read enable.
REQ-013 SHALL have port rd_address, input, ADDRESSWIDTH bits: read row address within the layer.
REQ-014 SHALL have port rd_layer, input, 1 bit: read layer select.
REQ-015 SHALL have port wr_data, input, DW bits: write data.
REQ-016 SHALL have port wr_en, input, 1 bit: write enable; there is no external write address.

Function
REQ-017 SHALL store DEPTH words of DW bits; linear index = layer*ADDRDEPTH + address.
REQ-018 SHALL read asynchronously from the array and register the result: when rd_en=1 at a rising edge, rd_data_regout shall take mem[rd_layer*ADDRDEPTH + rd_address] (1-cycle latency).
REQ-019 SHALL hold rd_data_regout unchanged on any edge where rd_en=0.
REQ-020 SHALL hold the write location in an internal pointer (wr_layer, wr_addr), both reset to 0.
REQ-021 SHALL, when wr_en=1 at a rising edge, write wr_data to mem[wr_layer*ADDRDEPTH + wr_addr], then advance the pointer.
REQ-022 SHALL advance the pointer by incrementing wr_addr; at wr_addr = ADDRDEPTH-1 it shall wrap to 0 and toggle wr_layer; wr_layer 1 shall wrap to 0.
REQ-023 SHALL leave the pointer unchanged on edges where wr_en=0.
REQ-024 SHALL return the old (pre-write) contents on a simultaneous read and write to the same location; the new data is visible from the next read edge.
REQ-025 SHALL make reads with rd_address >= ADDRDEPTH return an all-zero word into rd_data_regout.
REQ-026 SHALL treat the data word as opaque; no arithmetic or saturation is applied.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear rd_data_regout to 0, and clear wr_addr and wr_layer to 0.
REQ-028 SHALL NOT clear the memory array on reset; contents persist across reset (LUT-RAM friendly).
REQ-029 SHALL, if reset is asserted mid-stream, abandon any in-flight write on that edge, and start the next write at layer 0, address 0.

Structure
REQ-030 SHALL take W, P, NB, WT, ADDRESSWIDTH, ADDRDEPTH, LAYERS and the derived DW and DEPTH from the shared decoder parameter package.
REQ-031 SHALL contain one natural sub-module, dmem_wr_ptr (the wr_addr/wr_layer counter); the array and output register stay in the top.

Verification
REQ-032 SHALL verify reset: with rst=0, rd_data_regout = 0; after release, the first write lands at layer 0, address 0.
REQ-033 SHALL verify sequential fill: release reset, 20 writes of pattern k (k = 0..19) with wr_en=1 -> reads at layer 0, address k return pattern k one cycle after rd_en.
REQ-034 SHALL verify layer wrap: 21st write (pattern 0xAA..) -> read at layer 1, address 0 returns 0xAA..; layer 0, address 0 is unchanged.
REQ-035 SHALL verify read-during-write: write A then B to the same location while reading it on the B write edge -> output A; next edge -> output B.
REQ-036 SHALL verify output hold: rd_en=0 while rd_address changes -> rd_data_regout holds its last value.
REQ-037 SHALL verify out-of-range read: rd_address = 25, rd_en=1 -> rd_data_regout = 0.
